// File: rtl/dip_switch_ctrl.sv
// dip_switch_ctrl: synchronizes, debounces and change-detects 64 DIP switches behind a bus register window
module dip_switch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:2] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  input  logic [7:0]  dip_switch0,
  input  logic [7:0]  dip_switch1,
  input  logic [7:0]  dip_switch2,
  input  logic [7:0]  dip_switch3,
  input  logic [7:0]  dip_switch4,
  input  logic [7:0]  dip_switch5,
  input  logic [7:0]  dip_switch6,
  input  logic [7:0]  dip_switch7,
  output logic        IRQ
);
  logic [7:0][7:0] pins, sync1, sync2, cand, stable;
  logic [7:0][CNT_W-1:0] cnt;
  logic [7:0] chg, done;
  logic pending, irq_en;
  logic [31:0] byte_addr;
  logic wr_ctrl, clr;
  logic din_unused;
  assign pins = {dip_switch7, dip_switch6, dip_switch5, dip_switch4,
                 dip_switch3, dip_switch2, dip_switch1, dip_switch0};
  assign byte_addr = {Addr, 2'b00};
  assign wr_ctrl = WE && byte_addr == 32'h7f34;
  assign clr = wr_ctrl && Din[1];
  assign IRQ = irq_en & pending;
  assign din_unused = ^Din[31:2];
  genvar g;
  generate
    for (g = 0; g < 8; g++) begin : g_done
      assign done[g] = sync2[g] == cand[g] && cand[g] != stable[g] &&
                       cnt[g] == CNT_W'(DEBOUNCE_CYCLES - 1);
    end
  endgenerate
  // Synchronizer, per-group debounce counters, and sticky change/interrupt state; a new change beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
      cand <= '0;
      stable <= '0;
      cnt <= '0;
      chg <= '0;
      pending <= 1'b0;
      irq_en <= 1'b0;
    end else begin
      sync1 <= pins;
      sync2 <= sync1;
      for (int i = 0; i < 8; i++) begin
        if (sync2[i] != cand[i]) begin
          cand[i] <= sync2[i];
          cnt[i] <= '0;
        end else if (done[i]) begin
          stable[i] <= cand[i];
          cnt[i] <= '0;
        end else if (cand[i] != stable[i]) begin
          cnt[i] <= cnt[i] + 1'b1;
        end else begin
          cnt[i] <= '0;
        end
      end
      chg <= (clr ? 8'd0 : chg) | done;
      pending <= (clr ? 1'b0 : pending) | (|done);
      if (wr_ctrl) irq_en <= Din[0];
    end
  end
  // Same-cycle register read mux
  always_comb begin
    Dout = byte_addr == 32'h7f2c ? stable[3:0] :
           byte_addr == 32'h7f30 ? stable[7:4] :
           byte_addr == 32'h7f34 ? {16'd0, chg, 6'd0, pending, irq_en} : 32'd0;
  end
endmodule

// File: tb/tb_dip_switch_ctrl.sv
// tb_dip_switch_ctrl: directed self-checking bench for dip_switch_ctrl with DEBOUNCE_CYCLES=4
module tb_dip_switch_ctrl;
  logic clk = 0;
  logic reset = 0;
  logic [31:2] addr = '0;
  logic we = 0;
  logic [31:0] din = '0;
  logic [31:0] dout;
  logic [7:0] sw0 = 0, sw1 = 0, sw2 = 0, sw3 = 0, sw4 = 0, sw5 = 0, sw6 = 0, sw7 = 0;
  logic irq;
  int checks = 0;
  int fails = 0;

  dip_switch_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .Addr(addr), .WE(we), .Din(din), .Dout(dout),
    .dip_switch0(sw0), .dip_switch1(sw1), .dip_switch2(sw2), .dip_switch3(sw3),
    .dip_switch4(sw4), .dip_switch5(sw5), .dip_switch6(sw6), .dip_switch7(sw7),
    .IRQ(irq)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input logic [31:0] a);
    addr = a[31:2];
    #1;
  endtask

  task automatic wr_setup(input logic [31:0] a, input logic [31:0] d);
    addr = a[31:2];
    din = d;
    we = 1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    wr_setup(a, d);
    tick(1);
    we = 0;
  endtask

  task automatic test_reset;
    reset = 0;
    tick(3);
    reset = 1;
    rd(32'h7f2c);
    checks++; if (dout !== 32'h0) begin fails++; $display("FAIL reset_lo got %h exp %h", dout, 32'h0); end
    rd(32'h7f30);
    checks++; if (dout !== 32'h0) begin fails++; $display("FAIL reset_hi got %h exp %h", dout, 32'h0); end
    rd(32'h7f34);
    checks++; if (dout !== 32'h0) begin fails++; $display("FAIL reset_ctrl got %h exp %h", dout, 32'h0); end
    checks++; if (irq !== 1'b0) begin fails++; $display("FAIL reset_irq got %b exp 0", irq); end
  endtask

  task automatic test_latency;
    wr(32'h7f34, 32'h1);
    sw2 = 8'hA5;
    tick(1);
    tick(5);
    rd(32'h7f2c);
    checks++; if (dout !== 32'h0) begin fails++; $display("FAIL lat_early got %h exp %h", dout, 32'h0); end
    checks++; if (irq !== 1'b0) begin fails++; $display("FAIL lat_early_irq got %b exp 0", irq); end
    tick(1);
    rd(32'h7f2c);
    checks++; if (dout !== 32'h00A50000) begin fails++; $display("FAIL lat_value got %h exp %h", dout, 32'h00A50000); end
    rd(32'h7f34);
    checks++; if (dout !== 32'h00000403) begin fails++; $display("FAIL lat_ctrl got %h exp %h", dout, 32'h00000403); end
    checks++; if (irq !== 1'b1) begin fails++; $display("FAIL lat_irq got %b exp 1", irq); end
    wr(32'h7f34, 32'h3);
    checks++; if (irq !== 1'b0) begin fails++; $display("FAIL lat_clear_irq got %b exp 0", irq); end
  endtask

  task automatic test_bounce;
    sw5 = 8'hFF;
    tick(2);
    sw5 = 8'h00;
    tick(2);
    sw5 = 8'hFF;
    tick(1);
    tick(5);
    rd(32'h7f30);
    checks++; if (dout !== 32'h0) begin fails++; $display("FAIL bounce_early got %h exp %h", dout, 32'h0); end
    rd(32'h7f34);
    checks++; if (dout !== 32'h00000001) begin fails++; $display("FAIL bounce_early_ctrl got %h exp %h", dout, 32'h1); end
    tick(1);
    rd(32'h7f30);
    checks++; if (dout !== 32'h0000FF00) begin fails++; $display("FAIL bounce_value got %h exp %h", dout, 32'h0000FF00); end
    tick(3);
    rd(32'h7f34);
    checks++; if (dout !== 32'h00002003) begin fails++; $display("FAIL bounce_chg got %h exp %h", dout, 32'h00002003); end
    wr(32'h7f34, 32'h3);
  endtask

  task automatic test_glitch;
    sw0 = 8'h01;
    tick(3);
    sw0 = 8'h00;
    tick(10);
    rd(32'h7f2c);
    checks++; if (dout !== 32'h00A50000) begin fails++; $display("FAIL glitch_value got %h exp %h", dout, 32'h00A50000); end
    rd(32'h7f34);
    checks++; if (dout !== 32'h00000001) begin fails++; $display("FAIL glitch_ctrl got %h exp %h", dout, 32'h1); end
    checks++; if (irq !== 1'b0) begin fails++; $display("FAIL glitch_irq got %b exp 0", irq); end
  endtask

  task automatic test_set_beats_clear;
    sw4 = 8'h11;
    tick(8);
    rd(32'h7f34);
    checks++; if (dout !== 32'h00001003) begin fails++; $display("FAIL pre_clear_ctrl got %h exp %h", dout, 32'h00001003); end
    sw7 = 8'h3C;
    tick(1);
    tick(5);
    wr(32'h7f34, 32'h3);
    rd(32'h7f34);
    checks++; if (dout !== 32'h00008003) begin fails++; $display("FAIL set_wins_ctrl got %h exp %h", dout, 32'h00008003); end
    checks++; if (irq !== 1'b1) begin fails++; $display("FAIL set_wins_irq got %b exp 1", irq); end
    rd(32'h7f30);
    checks++; if (dout !== 32'h3C00FF11) begin fails++; $display("FAIL set_wins_hi got %h exp %h", dout, 32'h3C00FF11); end
    wr(32'h7f34, 32'h3);
  endtask

  task automatic test_multi;
    sw1 = 8'h5A;
    sw6 = 8'hC3;
    tick(1);
    tick(6);
    rd(32'h7f34);
    checks++; if (dout !== 32'h00004203) begin fails++; $display("FAIL multi_ctrl got %h exp %h", dout, 32'h00004203); end
    rd(32'h7f2c);
    checks++; if (dout !== 32'h00A55A00) begin fails++; $display("FAIL multi_lo got %h exp %h", dout, 32'h00A55A00); end
    rd(32'h7f30);
    checks++; if (dout !== 32'h3CC3FF11) begin fails++; $display("FAIL multi_hi got %h exp %h", dout, 32'h3CC3FF11); end
  endtask

  task automatic test_clear_and_ignored;
    wr(32'h7f34, 32'h2);
    rd(32'h7f34);
    checks++; if (dout !== 32'h0) begin fails++; $display("FAIL clear_ctrl got %h exp %h", dout, 32'h0); end
    checks++; if (irq !== 1'b0) begin fails++; $display("FAIL clear_irq got %b exp 0", irq); end
    wr(32'h7f2c, 32'hFFFFFFFF);
    wr(32'h7f30, 32'h0);
    rd(32'h7f2c);
    checks++; if (dout !== 32'h00A55A00) begin fails++; $display("FAIL ro_lo got %h exp %h", dout, 32'h00A55A00); end
    rd(32'h7f30);
    checks++; if (dout !== 32'h3CC3FF11) begin fails++; $display("FAIL ro_hi got %h exp %h", dout, 32'h3CC3FF11); end
    rd(32'h7f28);
    checks++; if (dout !== 32'h0) begin fails++; $display("FAIL unmapped got %h exp %h", dout, 32'h0); end
    rd(32'h00007f34 | 32'h00010000);
    checks++; if (dout !== 32'h0) begin fails++; $display("FAIL alias got %h exp %h", dout, 32'h0); end
  endtask

  task automatic test_reset_mid_count;
    sw3 = 8'h77;
    tick(3);
    reset = 0;
    tick(1);
    reset = 1;
    tick(1);
    tick(5);
    rd(32'h7f34);
    checks++; if (dout !== 32'h0) begin fails++; $display("FAIL rst_mid_early got %h exp %h", dout, 32'h0); end
    rd(32'h7f2c);
    checks++; if (dout !== 32'h0) begin fails++; $display("FAIL rst_mid_lo_early got %h exp %h", dout, 32'h0); end
    tick(1);
    rd(32'h7f34);
    checks++; if (dout !== 32'h0000FE02) begin fails++; $display("FAIL rst_mid_ctrl got %h exp %h", dout, 32'h0000FE02); end
    checks++; if (irq !== 1'b0) begin fails++; $display("FAIL rst_mid_irq got %b exp 0", irq); end
    rd(32'h7f2c);
    checks++; if (dout !== 32'h77A55A00) begin fails++; $display("FAIL rst_mid_lo got %h exp %h", dout, 32'h77A55A00); end
    wr(32'h7f34, 32'h1);
    checks++; if (irq !== 1'b1) begin fails++; $display("FAIL rst_mid_irq_en got %b exp 1", irq); end
  endtask

  initial begin
    #1;
    test_reset;
    test_latency;
    test_bounce;
    test_glitch;
    test_set_beats_clear;
    test_multi;
    test_clear_and_ignored;
    test_reset_mid_count;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
